// File: rtl/core_cmd_responder.sv
// ---------------------------------------------------------------------------
// core_cmd_responder
//
// Mesh-side endpoint of the boot/programming command bus. One command is
// sampled per rising clock edge whenever operation != NOP. Each core keeps
// a small power/reset/run state machine (OFF, HELD, RUNNING) and a program
// counter. STATUS queries are answered through a show-ahead response queue.
//
// Ports
//   clock, RST          : clock; asynchronous active-high reset
//   operation           : opcode (NOP=0000, PWR=0011, START=1010, STATUS=0101)
//   core_ID             : target core
//   ON, reset           : PWR operands
//   start, prog_address : START qualifier and start PC
//   out_ready           : response consumer ready
//   core_on             : per-core power enable (state != OFF)
//   core_reset          : per-core reset (state != RUNNING)
//   core_start          : per-core one-cycle start pulse
//   core_pc             : per-core PC, core i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   origin, data_out    : response at the queue head (zero when empty)
//   valid_out           : response available
//   err_count           : saturating count of rejected commands
//   rsp_overflow        : sticky, a STATUS response was dropped
//   core_state          : per-core state, core i at [2*i +: 2] (debug view)
//
// Response handshake: a response is transferred on a rising edge where
// valid_out && out_ready. While valid_out=1 and out_ready=0 the head entry
// (origin/data_out) is held unchanged; valid_out never drops without a pop.
// ---------------------------------------------------------------------------
module core_cmd_responder #(
  parameter int CORES      = 16,
  parameter int ID_BITS    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                        clock,
  input  logic                        RST,
  input  logic [3:0]                  operation,
  input  logic [ID_BITS-1:0]          core_ID,
  input  logic                        ON,
  input  logic                        reset,
  input  logic                        start,
  input  logic [ADDR_WIDTH-1:0]       prog_address,
  input  logic                        out_ready,
  output logic [CORES-1:0]            core_on,
  output logic [CORES-1:0]            core_reset,
  output logic [CORES-1:0]            core_start,
  output logic [CORES*ADDR_WIDTH-1:0] core_pc,
  output logic [ID_BITS-1:0]          origin,
  output logic [31:0]                 data_out,
  output logic                        valid_out,
  output logic [7:0]                  err_count,
  output logic                        rsp_overflow,
  output logic [2*CORES-1:0]          core_state
);

  localparam logic [3:0] OP_NOP    = 4'b0000;
  localparam logic [3:0] OP_PWR    = 4'b0011;
  localparam logic [3:0] OP_START  = 4'b1010;
  localparam logic [3:0] OP_STATUS = 4'b0101;

  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int ENT_W = ID_BITS + 32;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_HELD = 2'd1,
    ST_RUN  = 2'd2
  } core_state_t;

  core_state_t           state_q [CORES];
  core_state_t           state_d [CORES];
  logic [ADDR_WIDTH-1:0] pc_q    [CORES];
  logic [ADDR_WIDTH-1:0] pc_d    [CORES];
  logic [CORES-1:0]      start_d;
  logic                  err_inc;
  logic                  push_req;
  logic [ENT_W-1:0]      push_word;
  logic                  id_ok;

  // -------------------------------------------------------------------------
  // Command decode / per-core next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    start_d   = '0;
    err_inc   = 1'b0;
    push_req  = 1'b0;
    push_word = '0;
    id_ok     = (int'(core_ID) < CORES);

    if (operation != OP_NOP) begin
      if (!id_ok) begin
        // Out-of-range target: rejected, nothing else happens.
        err_inc = 1'b1;
      end else begin
        case (operation)
          OP_PWR: begin
            if (!ON) begin
              state_d[core_ID] = ST_OFF;
            end else if (reset) begin
              state_d[core_ID] = ST_HELD;
            end else begin
              // Release from reset resumes at the current PC, no start pulse.
              case (state_q[core_ID])
                ST_HELD: state_d[core_ID] = ST_RUN;
                ST_RUN:  state_d[core_ID] = ST_RUN;
                default: err_inc = 1'b1;
              endcase
            end
          end
          OP_START: begin
            if (start) begin
              if (state_q[core_ID] == ST_HELD) begin
                pc_d[core_ID]    = prog_address;
                state_d[core_ID] = ST_RUN;
                start_d[core_ID] = 1'b1;
              end else begin
                err_inc = 1'b1;
              end
            end
          end
          OP_STATUS: begin
            // Snapshot of the pre-edge values of the addressed core.
            push_req  = 1'b1;
            push_word = {core_ID,
                         state_q[core_ID],
                         (state_q[core_ID] != ST_OFF),
                         (state_q[core_ID] != ST_RUN),
                         pc_q[core_ID][27:0]};
          end
          default: err_inc = 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge clock or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < CORES; i++) begin
        state_q[i] <= ST_OFF;
        pc_q[i]    <= '0;
      end
      core_start <= '0;
      err_count  <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      core_start <= start_d;
      if (err_inc && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

  always_comb begin
    core_on    = '0;
    core_reset = '0;
    core_pc    = '0;
    core_state = '0;
    for (int i = 0; i < CORES; i++) begin
      core_on[i]                           = (state_q[i] != ST_OFF);
      core_reset[i]                        = (state_q[i] != ST_RUN);
      core_pc[i*ADDR_WIDTH +: ADDR_WIDTH]  = pc_q[i];
      core_state[2*i +: 2]                 = state_q[i];
    end
  end

  // -------------------------------------------------------------------------
  // Show-ahead response queue
  // -------------------------------------------------------------------------
  logic [ENT_W-1:0] rsp_mem [RSP_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             full;
  logic             pop;
  logic             push_ok;

  assign full      = (count == (PTR_W+1)'(RSP_DEPTH));
  assign valid_out = (count != '0);
  assign pop       = valid_out && out_ready;
  // A pop on the same edge frees the slot the push needs.
  assign push_ok   = push_req && (!full || pop);

  // Head is masked when empty so the return path idles at zero.
  assign origin   = valid_out ? rsp_mem[rd_ptr][ENT_W-1:32] : '0;
  assign data_out = valid_out ? rsp_mem[rd_ptr][31:0]       : '0;

  always_ff @(posedge clock or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < RSP_DEPTH; i++) begin
        rsp_mem[i] <= '0;
      end
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      rsp_overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        rsp_mem[wr_ptr] <= push_word;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push_ok, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
      if (push_req && !push_ok) begin
        rsp_overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_core_cmd_responder.sv
module tb_core_cmd_responder;

  localparam int CORES      = 16;
  localparam int ID_BITS    = 4;
  localparam int ADDR_WIDTH = 32;
  localparam int RSP_DEPTH  = 4;

  localparam logic [3:0] NOP    = 4'b0000;
  localparam logic [3:0] PWR    = 4'b0011;
  localparam logic [3:0] START  = 4'b1010;
  localparam logic [3:0] STATUS = 4'b0101;
  localparam logic [3:0] BADOP  = 4'b1111;

  // clock / reset
  logic clock = 1'b0;
  logic RST   = 1'b1;
  always #5 clock = ~clock;

  logic [3:0]                  operation    = NOP;
  logic [ID_BITS-1:0]          core_ID      = '0;
  logic                        ON           = 1'b0;
  logic                        reset        = 1'b0;
  logic                        start        = 1'b0;
  logic [ADDR_WIDTH-1:0]       prog_address = '0;
  logic                        out_ready    = 1'b0;
  logic [CORES-1:0]            core_on;
  logic [CORES-1:0]            core_reset;
  logic [CORES-1:0]            core_start;
  logic [CORES*ADDR_WIDTH-1:0] core_pc;
  logic [ID_BITS-1:0]          origin;
  logic [31:0]                 data_out;
  logic                        valid_out;
  logic [7:0]                  err_count;
  logic                        rsp_overflow;
  logic [2*CORES-1:0]          core_state;

  core_cmd_responder #(
    .CORES(CORES), .ID_BITS(ID_BITS), .ADDR_WIDTH(ADDR_WIDTH), .RSP_DEPTH(RSP_DEPTH)
  ) dut (
    .clock(clock), .RST(RST), .operation(operation), .core_ID(core_ID),
    .ON(ON), .reset(reset), .start(start), .prog_address(prog_address),
    .out_ready(out_ready), .core_on(core_on), .core_reset(core_reset),
    .core_start(core_start), .core_pc(core_pc), .origin(origin),
    .data_out(data_out), .valid_out(valid_out), .err_count(err_count),
    .rsp_overflow(rsp_overflow), .core_state(core_state)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one command for one edge, then sample 1 time unit after the edge.
  task automatic cmd(input logic [3:0] op, input int id, input logic on, input logic rs,
                     input logic st, input logic [31:0] addr);
    operation    = op;
    core_ID      = ID_BITS'(id);
    ON           = on;
    reset        = rs;
    start        = st;
    prog_address = addr;
    @(posedge clock);
    #1;
    operation    = NOP;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  function automatic logic [31:0] pc_of(input int i);
    return core_pc[i*ADDR_WIDTH +: ADDR_WIDTH];
  endfunction

  initial begin
    logic [15:0] exp_pulse;

    // ---------------- reset state
    repeat (2) @(posedge clock);
    #1;
    check("rst_core_on",    core_on, 16'h0000);
    check("rst_core_reset", core_reset, 16'hFFFF);
    check("rst_core_start", core_start, 16'h0000);
    check("rst_valid",      valid_out, 1'b0);
    check("rst_err",        err_count, 8'd0);
    check("rst_ovf",        rsp_overflow, 1'b0);
    RST = 1'b0;

    // ---------------- PWR boot: all cores HELD
    for (int i = 0; i < 16; i++) cmd(PWR, i, 1'b1, 1'b1, 1'b0, 32'h0);
    check("boot_core_on",    core_on, 16'hFFFF);
    check("boot_core_reset", core_reset, 16'hFFFF);
    check("boot_err",        err_count, 8'd0);
    check("boot_state0",     core_state[1:0], 2'd1);

    // ---------------- START sweep
    for (int i = 0; i < 16; i++) begin
      cmd(START, i, 1'b0, 1'b0, 1'b1, 32'(i) * 32'h400000 + 32'h10);
      exp_pulse = 16'h1 << i;
      check("sweep_pulse", core_start, exp_pulse);
    end
    check("sweep_pc15",      pc_of(15), 32'h3C00010);
    check("sweep_pc4",       pc_of(4), 32'h1000010);
    check("sweep_reset",     core_reset, 16'h0000);
    idle(1);
    check("sweep_pulse_end", core_start, 16'h0000);
    check("sweep_err",       err_count, 8'd0);

    // ---------------- illegal transitions and no-error cases
    cmd(PWR, 7, 1'b0, 1'b0, 1'b0, 32'h0);
    check("off7_on",    core_on, 16'hFF7F);
    check("off7_reset", core_reset, 16'h0080);
    cmd(START, 7, 1'b0, 1'b0, 1'b1, 32'hDEAD0000);
    check("start_off_err",   err_count, 8'd1);
    check("start_off_pulse", core_start, 16'h0000);
    check("start_off_pc",    pc_of(7), 32'h1C00010);
    cmd(START, 2, 1'b0, 1'b0, 1'b1, 32'h12345678);
    check("start_run_err",   err_count, 8'd2);
    check("start_run_pulse", core_start, 16'h0000);
    check("start_run_pc",    pc_of(2), 32'h800010);
    cmd(BADOP, 1, 1'b0, 1'b0, 1'b0, 32'h0);
    check("badop_err", err_count, 8'd3);
    cmd(START, 7, 1'b0, 1'b0, 1'b0, 32'hDEAD0000);
    check("start_q0_err", err_count, 8'd3);
    cmd(PWR, 3, 1'b1, 1'b0, 1'b0, 32'h0);
    check("release_run_err",   err_count, 8'd3);
    check("release_run_reset", core_reset, 16'h0080);
    cmd(PWR, 7, 1'b1, 1'b1, 1'b0, 32'h0);
    check("hold7_on", core_on, 16'hFFFF);
    cmd(PWR, 7, 1'b1, 1'b0, 1'b0, 32'h0);
    check("resume7_reset", core_reset, 16'h0000);
    check("resume7_pulse", core_start, 16'h0000);
    check("resume7_pc",    pc_of(7), 32'h1C00010);
    check("resume7_err",   err_count, 8'd3);

    // ---------------- simultaneous push/pop on a full queue
    out_ready = 1'b0;
    for (int i = 8; i < 12; i++) cmd(STATUS, i, 1'b0, 1'b0, 1'b0, 32'h0);
    check("fill_valid",  valid_out, 1'b1);
    check("fill_origin", origin, 4'd8);
    check("fill_data",   data_out, 32'hA2000010);
    check("fill_ovf",    rsp_overflow, 1'b0);
    out_ready = 1'b1;
    cmd(STATUS, 12, 1'b0, 1'b0, 1'b0, 32'h0);
    check("pp_ovf",    rsp_overflow, 1'b0);
    check("pp_origin", origin, 4'd9);
    check("pp_data",   data_out, 32'hA2400010);
    idle(1);
    check("pp_drain10", origin, 4'd10);
    idle(1);
    check("pp_drain11", origin, 4'd11);
    idle(1);
    check("pp_drain12",      origin, 4'd12);
    check("pp_drain12_data", data_out, 32'hA3000010);
    idle(1);
    check("pp_empty", valid_out, 1'b0);
    out_ready = 1'b0;

    // ---------------- STATUS backpressure with overflow
    for (int i = 0; i < 5; i++) begin
      cmd(STATUS, i, 1'b0, 1'b0, 1'b0, 32'h0);
      if (i == 3) check("bp_ovf_before", rsp_overflow, 1'b0);
    end
    check("bp_ovf",    rsp_overflow, 1'b1);
    check("bp_origin", origin, 4'd0);
    check("bp_data0",  data_out, 32'hA0000010);
    check("bp_err",    err_count, 8'd3);
    out_ready = 1'b1;
    idle(1);
    check("bp_origin1", origin, 4'd1);
    check("bp_data1",   data_out, 32'hA0400010);
    idle(1);
    check("bp_origin2", origin, 4'd2);
    idle(1);
    check("bp_origin3", origin, 4'd3);
    idle(1);
    check("bp_empty", valid_out, 1'b0);
    out_ready = 1'b0;

    // ---------------- asynchronous reset mid-handshake / mid-pulse
    cmd(STATUS, 7, 1'b0, 1'b0, 1'b0, 32'h0);
    check("ar_valid",  valid_out, 1'b1);
    check("ar_origin", origin, 4'd7);
    cmd(PWR, 7, 1'b1, 1'b1, 1'b0, 32'h0);
    cmd(START, 7, 1'b0, 1'b0, 1'b1, 32'h1234);
    check("ar_pulse", core_start, 16'h0080);
    check("ar_pc7",   pc_of(7), 32'h1234);
    #2;
    RST = 1'b1;
    #1;
    check("ar_core_on",    core_on, 16'h0000);
    check("ar_core_reset", core_reset, 16'hFFFF);
    check("ar_core_start", core_start, 16'h0000);
    check("ar_core_pc",    (core_pc == '0), 1'b1);
    check("ar_valid0",     valid_out, 1'b0);
    check("ar_origin0",    origin, 4'd0);
    check("ar_data0",      data_out, 32'h0);
    check("ar_err0",       err_count, 8'd0);
    check("ar_ovf0",       rsp_overflow, 1'b0);
    RST = 1'b0;
    cmd(PWR, 0, 1'b1, 1'b0, 1'b0, 32'h0);
    check("post_rst_err", err_count, 8'd1);
    check("post_rst_on",  core_on, 16'h0000);

    // ---------------- error counter saturation
    for (int i = 0; i < 260; i++) cmd(BADOP, 0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("err_saturate", err_count, 8'hFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
